// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, parity/stop check, optional UART_RX_SYNC_EN input synchronizer.
// Latency: pulse 1 cycle after stop sample (+2 with sync); no backpressure, pulses must be taken on sight.
module uart_rx #(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BAUDRATE   = 115200,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                         o_user_rx_valid,
    output logic                         o_user_rx_err
);

    localparam int          DIV     = P_SYSTEM_CLK / P_UART_BAUDRATE;
    localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(DIV - 1);
    localparam logic [3:0]  LAST    = 4'(P_UART_DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic                         rx_line;
    logic                         r_rx_d0, r_rx_d1;
    state_t                       state_q, state_d;
    logic [15:0]                  cnt_q, cnt_d;
    logic [3:0]                   bit_q, bit_d;
    logic [P_UART_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                         r_par_ok, par_ok_d;
    logic [P_UART_DATA_WIDTH-1:0] data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         err_q, err_d;
    logic                         full;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], i_uart_rx};
    end
    assign rx_line = sync_q[1];
`else
    assign rx_line = i_uart_rx;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_d0  <= 1'b1;
            r_rx_d1  <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            r_par_ok <= 1'b1;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            r_rx_d0  <= rx_line;
            r_rx_d1  <= r_rx_d0;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            r_par_ok <= par_ok_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign full = (cnt_q == FULL_M1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_ok_d = r_par_ok;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                bit_d    = '0;
                par_ok_d = 1'b1;
                // Edge, not level: a line stuck low cannot retrigger.
                if (r_rx_d1 && !r_rx_d0) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = r_rx_d0 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full) begin
                    cnt_d   = '0;
                    shift_d = {r_rx_d0, shift_q[P_UART_DATA_WIDTH-1:1]};
                    if (bit_q == LAST) state_d = (P_UART_CHECK != 0) ? PARITY : STOP;
                    else               bit_d   = bit_q + 4'd1;
                end
            end
            PARITY: begin
                if (full) begin
                    cnt_d    = '0;
                    par_ok_d = (P_UART_CHECK == 1) ? (^shift_q ^ r_rx_d0) : ~(^shift_q ^ r_rx_d0);
                    state_d  = STOP;
                end
            end
            STOP: begin
                // Leave on the sample itself so a back-to-back start edge is not missed.
                if (full) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (r_rx_d0 && r_par_ok) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_user_rx_data  = data_q;
    assign o_user_rx_valid = valid_q;
    assign o_user_rx_err   = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: DUT a without parity, DUT b with even parity, DIV = 16.
module tb_uart_rx;

    localparam int CLK  = 1_600_000;
    localparam int BAUD = 100_000;
    localparam int DIV  = 16;
    localparam int W    = 8;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_a = 1'b1, line_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       vld_a, err_a, vld_b, err_b;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.P_SYSTEM_CLK(CLK), .P_UART_BAUDRATE(BAUD), .P_UART_DATA_WIDTH(W), .P_UART_CHECK(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(line_a),
        .o_user_rx_data(data_a), .o_user_rx_valid(vld_a), .o_user_rx_err(err_a));

    uart_rx #(.P_SYSTEM_CLK(CLK), .P_UART_BAUDRATE(BAUD), .P_UART_DATA_WIDTH(W), .P_UART_CHECK(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(line_b),
        .o_user_rx_data(data_b), .o_user_rx_valid(vld_b), .o_user_rx_err(err_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (vld_a || err_a) begin
            check("a_exclusive", 32'(vld_a & err_a), 32'd0);
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: vld=%0b err=%0b data=%0h at cycle %0d, no pulse expected",
                         vld_a, err_a, data_a, cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_kind_err", 32'(err_a), 32'(e.is_err));
                check("a_data", 32'(data_a), 32'(e.data));
                check("a_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    always @(negedge clk) begin
        if (vld_b || err_b) begin
            check("b_exclusive", 32'(vld_b & err_b), 32'd0);
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: vld=%0b err=%0b data=%0h at cycle %0d, no pulse expected",
                         vld_b, err_b, data_b, cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_kind_err", 32'(err_b), 32'(e.is_err));
                check("b_data", 32'(data_b), 32'(e.data));
                check("b_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic set_line(input bit sel, input logic v);
        if (sel) line_b = v;
        else     line_a = v;
    endtask

    // Called just after a rising edge; each bit is held DIV cycles. kind: 0 none, 1 valid, 2 err.
    // par < 0 means no parity bit. The line is left at the stop-bit level on return.
    task automatic send(input bit sel, input logic [7:0] d, input int par, input logic stop,
                        input int rst_bit, input int kind, input logic [7:0] exp_data);
        logic bits [0:11];
        int   n;
        int   lat;
        exp_t e;
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[1+i] = d[i];
        n = 1 + W;
        if (par >= 0) begin
            bits[n] = par[0];
            n++;
        end
        bits[n] = stop;
        n++;
        // Edge lands in r_rx_d0 on the first clock after the drive (t0); stop sample at t0+DIV/2+F*DIV.
        lat = 1 + DIV / 2 + (n - 1) * DIV + 1 + SYNC_LAT;
        if (kind != 0) begin
            e.is_err = (kind == 2);
            e.data   = exp_data;
            e.at     = cyc + lat;
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            set_line(sel, bits[i]);
            if (i == rst_bit) begin
                repeat (DIV / 2) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                repeat (DIV / 2 - 1) @(posedge clk);
                #1;
            end else begin
                repeat (DIV) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(3);
        check("rst_data_a", 32'(data_a), 32'd0);
        check("rst_vld_a", 32'(vld_a), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_data_b", 32'(data_b), 32'd0);
        check("rst_vld_b", 32'(vld_b), 32'd0);
        check("rst_err_b", 32'(err_b), 32'd0);
        rst = 1'b0;
        idle(10);

        // Even parity: 0x07 has three ones, so parity 1 is good and 0 is bad.
        send(1'b1, 8'h07, 1, 1'b1, -1, 1, 8'h07);
        send(1'b1, 8'h07, 0, 1'b1, -1, 2, 8'h07);
        idle(20);

        // No parity, back-to-back.
        send(1'b0, 8'hA5, -1, 1'b1, -1, 1, 8'hA5);
        send(1'b0, 8'h3C, -1, 1'b1, -1, 1, 8'h3C);
        idle(20);

        // Framing error, then line held low: no restart until it goes high.
        send(1'b0, 8'h55, -1, 1'b0, -1, 2, 8'h3C);
        idle(3 * DIV);
        line_a = 1'b1;
        idle(20);

        // False start: 4-cycle low glitch.
        line_a = 1'b0;
        idle(4);
        line_a = 1'b1;
        idle(40);
        send(1'b0, 8'h81, -1, 1'b1, -1, 1, 8'h81);
        idle(20);

        // Reset during data bit 3 of 0xFF (frame index 4).
        send(1'b0, 8'hFF, -1, 1'b1, 4, 0, 8'h00);
        check("midrst_data_a", 32'(data_a), 32'd0);
        check("midrst_data_b", 32'(data_b), 32'd0);
        idle(40);
        check("midrst_quiet_vld", 32'(vld_a | vld_b), 32'd0);
        send(1'b0, 8'h12, -1, 1'b1, -1, 1, 8'h12);

        idle(200);
        check("a_pending", 32'(q_a.size()), 32'd0);
        check("b_pending", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
